// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: op codes, width and FSM encoding.
package alu_pkg;

   localparam int DATA_W = 4;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_SHR = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Logic ops leave the carry flag alone; arithmetic and shifts produce one.
   function automatic logic op_sets_carry(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SHL) || (op == OP_SHR);
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// Small register file: one synchronous write port, two operand read ports and a debug read port.
module alu_regfile #(
   parameter int DATA_W = 4,
   parameter int NREGS  = 4,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_b,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   logic [NREGS-1:0][DATA_W-1:0] rf;

   always_ff @(posedge clk) begin
      if (rst)
         rf <= '0;
      else if (we)
         rf[waddr] <= wdata;
   end

   assign rdata_a  = rf[raddr_a];
   assign rdata_b  = rf[raddr_b];
   assign dbg_data = rf[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/write-back controller for the 4-bit ALU: accept a command, drive registered
// operands for one cycle, then write the result back and update carry/zero flags.
module alu_issue_ctrl #(
   parameter int DATA_W = 4,
   parameter int NREGS  = 4,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_dst,
   input  logic [ADDR_W-1:0] cmd_src_a,
   input  logic [ADDR_W-1:0] cmd_src_b,
   input  logic              cmd_use_imm,
   input  logic [DATA_W-1:0] cmd_imm,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_op,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_carry,
   output logic              done,
   output logic              carry_flag,
   output logic              zero_flag,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   import alu_pkg::*;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] dst_q;
   logic [DATA_W-1:0] rd_a, rd_b;
   logic              accept, wb;

   alu_regfile #(
      .DATA_W(DATA_W),
      .NREGS (NREGS),
      .ADDR_W(ADDR_W)
   ) u_rf (
      .clk     (clk),
      .rst     (rst),
      .we      (wb),
      .waddr   (dst_q),
      .wdata   (alu_result),
      .raddr_a (cmd_src_a),
      .rdata_a (rd_a),
      .raddr_b (cmd_src_b),
      .rdata_b (rd_b),
      .dbg_addr(dbg_addr),
      .dbg_data(dbg_data)
   );

   always_comb begin
      state_d   = state_q;
      cmd_ready = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      wb        = 1'b0;
      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               accept  = 1'b1;
               state_d = EXEC;
            end
         end
         EXEC: begin
            wb      = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Operands are sampled at accept, so src == dst sees the pre-write-back value.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_op     <= '0;
         dst_q      <= '0;
         carry_flag <= 1'b0;
         zero_flag  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            alu_a  <= rd_a;
            alu_b  <= cmd_use_imm ? cmd_imm : rd_b;
            alu_op <= cmd_op;
            dst_q  <= cmd_dst;
         end
         if (wb) begin
            zero_flag <= (alu_result == '0);
            if (op_sets_carry(alu_op))
               carry_flag <= alu_carry;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl wired to a behavioural 4-bit ALU; expected results are queued at accept.
module tb_alu_issue_ctrl;

   import alu_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid, cmd_ready, cmd_use_imm;
   logic [2:0] cmd_op, alu_op;
   logic [1:0] cmd_dst, cmd_src_a, cmd_src_b, dbg_addr;
   logic [3:0] cmd_imm, alu_a, alu_b, alu_result, dbg_data;
   logic       alu_carry, done, carry_flag, zero_flag;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [1:0] dst;
      logic [2:0] op;
      logic [3:0] a, b, res;
      logic       c, z;
   } exp_t;

   exp_t       sb[$];
   logic [3:0] mrf[4];
   logic       mc, mz;

   always #5 clk = ~clk;

   alu_issue_ctrl #(.DATA_W(4), .NREGS(4), .ADDR_W(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_dst    (cmd_dst),
      .cmd_src_a  (cmd_src_a),
      .cmd_src_b  (cmd_src_b),
      .cmd_use_imm(cmd_use_imm),
      .cmd_imm    (cmd_imm),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_result (alu_result),
      .alu_carry  (alu_carry),
      .done       (done),
      .carry_flag (carry_flag),
      .zero_flag  (zero_flag),
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data)
   );

   // {carry, result}; SUB carry is the borrow out
   function automatic logic [4:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      case (op)
         OP_ADD:  return {1'b0, a} + {1'b0, b};
         OP_SUB:  return {1'b0, a} - {1'b0, b};
         OP_AND:  return {1'b0, a & b};
         OP_OR:   return {1'b0, a | b};
         OP_XOR:  return {1'b0, a ^ b};
         OP_NOT:  return {1'b0, ~a};
         OP_SHL:  return {a[3], a[2:0], 1'b0};
         OP_SHR:  return {a[0], 1'b0, a[3:1]};
         default: return 5'd0;
      endcase
   endfunction

   always_comb {alu_carry, alu_result} = alu_fn(alu_op, alu_a, alu_b);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic dbg_chk(input string tag, input logic [1:0] addr, input logic [3:0] exp);
      dbg_addr = addr;
      #1;
      chk(tag, dbg_data, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) mrf[i] = 4'd0;
      mc = 1'b0;
      mz = 1'b0;
   endtask

   // Called on a falling edge; returns on the falling edge of the done cycle (+1).
   task automatic issue(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                        input logic [1:0] sbr, input logic ui, input logic [3:0] imm,
                        input logic hold, output int waited);
      exp_t       e, g;
      logic [4:0] cr;
      int         w;
      cmd_op = op; cmd_dst = dst; cmd_src_a = sa; cmd_src_b = sbr;
      cmd_use_imm = ui; cmd_imm = imm; cmd_valid = 1'b1;
      w = 0;
      while (!cmd_ready && w < 10) begin
         @(negedge clk);
         w++;
      end
      waited = w;
      if (!cmd_ready) begin
         chk("accept_timeout", cmd_ready, 1);
         cmd_valid = 1'b0;
         return;
      end
      e.dst = dst; e.op = op; e.a = mrf[sa]; e.b = ui ? imm : mrf[sbr];
      cr = alu_fn(op, e.a, e.b);
      e.res = cr[3:0];
      mrf[dst] = e.res;
      if (op_sets_carry(op)) mc = cr[4];
      mz = (e.res == 4'd0);
      e.c = mc; e.z = mz;
      sb.push_back(e);
      @(negedge clk);
      chk("exec_ready", cmd_ready, 0);
      chk("exec_done", done, 0);
      chk("alu_op", alu_op, e.op);
      chk("alu_a", alu_a, e.a);
      chk("alu_b", alu_b, e.b);
      if (!hold) cmd_valid = 1'b0;
      @(negedge clk);
      chk("done_pulse", done, 1);
      chk("done_ready", cmd_ready, 0);
      if (sb.size() == 0) begin
         chk("sb_empty", sb.size(), 1);
         return;
      end
      g = sb.pop_front();
      chk("carry_flag", carry_flag, g.c);
      chk("zero_flag", zero_flag, g.z);
      chk("alu_held", alu_op, g.op);
      dbg_chk("wb_data", g.dst, g.res);
   endtask

   initial begin
      int w;
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_dst = '0; cmd_src_a = '0;
      cmd_src_b = '0; cmd_use_imm = 1'b0; cmd_imm = '0; dbg_addr = '0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      chk("rst_ready", cmd_ready, 1);
      chk("rst_done", done, 0);
      chk("rst_carry", carry_flag, 0);
      chk("rst_zero", zero_flag, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_op", alu_op, 0);
      for (int i = 0; i < 4; i++) dbg_chk("rst_rf", 2'(i), 4'd0);

      // OR load, then dependent ADD
      issue(OP_OR,  2'd1, 2'd0, 2'd0, 1'b1, 4'b0011, 1'b0, w);
      issue(OP_ADD, 2'd2, 2'd1, 2'd0, 1'b1, 4'b0101, 1'b0, w);
      dbg_chk("r1_0011", 2'd1, 4'b0011);
      dbg_chk("r2_1000", 2'd2, 4'b1000);
      chk("add_c0", carry_flag, 0);
      chk("add_z0", zero_flag, 0);

      // carry-out wraps to zero; XOR keeps carry sticky
      @(negedge clk);
      issue(OP_OR,  2'd1, 2'd0, 2'd0, 1'b1, 4'b1111, 1'b0, w);
      issue(OP_ADD, 2'd3, 2'd1, 2'd0, 1'b1, 4'b0001, 1'b0, w);
      dbg_chk("r3_0000", 2'd3, 4'b0000);
      chk("wrap_c1", carry_flag, 1);
      chk("wrap_z1", zero_flag, 1);
      issue(OP_XOR, 2'd0, 2'd1, 2'd0, 1'b1, 4'b1111, 1'b0, w);
      dbg_chk("r0_0000", 2'd0, 4'b0000);
      chk("xor_c_held", carry_flag, 1);
      chk("xor_z1", zero_flag, 1);

      // shifts
      issue(OP_OR,  2'd1, 2'd0, 2'd0, 1'b1, 4'b0011, 1'b0, w);
      issue(OP_SHL, 2'd2, 2'd1, 2'd0, 1'b0, 4'b0000, 1'b0, w);
      dbg_chk("r2_0110", 2'd2, 4'b0110);
      issue(OP_OR,  2'd3, 2'd0, 2'd0, 1'b1, 4'b1100, 1'b0, w);
      issue(OP_SHR, 2'd3, 2'd3, 2'd0, 1'b0, 4'b0000, 1'b0, w);
      dbg_chk("r3_0110", 2'd3, 4'b0110);

      // cmd_valid held high across six alternating commands
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0)
            issue(OP_ADD, 2'd0, 2'd0, 2'd0, 1'b1, 4'b0001, (i < 5), w);
         else
            issue(OP_XOR, 2'd1, 2'd1, 2'd0, 1'b1, 4'b0101, (i < 5), w);
         if (i > 0) chk("stream_gap", w, 1);
      end
      dbg_chk("stream_r0", 2'd0, 4'd3);
      dbg_chk("stream_r1", 2'd1, 4'b0110);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("no_extra_done", done, 0);
      end
      chk("sb_drained", sb.size(), 0);

      // reset during EXEC
      issue(OP_AND, 2'd1, 2'd1, 2'd0, 1'b1, 4'b0000, 1'b0, w);
      issue(OP_OR,  2'd1, 2'd1, 2'd0, 1'b1, 4'b0011, 1'b0, w);
      dbg_chk("pre_rst_r1", 2'd1, 4'b0011);
      cmd_op = OP_ADD; cmd_dst = 2'd2; cmd_src_a = 2'd1; cmd_use_imm = 1'b1;
      cmd_imm = 4'b0001; cmd_valid = 1'b1;
      w = 0;
      while (!cmd_ready && w < 10) begin
         @(negedge clk);
         w++;
      end
      chk("rst_exec_accept", cmd_ready, 1);
      @(negedge clk);
      chk("rst_exec_state", cmd_ready, 0);
      rst = 1'b1;
      cmd_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      chk("rst_exec_done", done, 0);
      chk("rst_exec_ready", cmd_ready, 1);
      @(negedge clk);
      chk("rst_exec_done2", done, 0);
      chk("rst_exec_carry", carry_flag, 0);
      chk("rst_exec_zero", zero_flag, 0);
      dbg_chk("rst_exec_r2", 2'd2, 4'b0000);
      dbg_chk("rst_exec_r1", 2'd1, 4'b0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
